mem_stage_vl: RTL and testbench

- Parametrised successor of the fixed-latency MEM stage: the pipeline memory stage for a data SRAM-like interface with variable response latency (req/data_ok style).
- Sits between EX and WB.
- Holds the instruction until its load or store response returns. Buffers an early response while WB stalls.
- Extracts and extends load data, and forwards results to ID.
- On a pipeline flush, discards responses to cancelled requests by counting them.

---
 rtl/mem_stage_vl_if.sv | 62 ++++++
 rtl/mem_stage_vl.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_vl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_vl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_vl_if
//  Brief    : EX->MEM, MEM->WB, data-SRAM response and forwarding signals
//             of the variable-latency MEM stage, bundled as one interface.
//             The slave modport is the MEM stage itself. The master modport
//             is its surroundings (EX, WB, SRAM and ID).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_vl_if #(
  parameter int PAYLOAD_W = 150
);
  // EX -> MEM
  logic                 ex_mem_valid;
  logic                 mem_allowin;
  logic [PAYLOAD_W-1:0] ex_mem_payload;
  logic                 ex_mem_req;
  logic                 ex_mem_ld;
  logic [2:0]           ex_mem_type;
  logic [1:0]           ex_mem_addr_low2;
  logic                 ex_mem_gr_we;
  logic [4:0]           ex_mem_dest;
  logic [31:0]          ex_mem_alu_result;
  // data SRAM response
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  // flush from WB
  logic                 mem_flush;
  // MEM -> WB
  logic                 mem_wb_valid;
  logic                 wb_allowin;
  logic [PAYLOAD_W-1:0] mem_wb_payload;
  logic                 mem_wb_gr_we;
  logic [4:0]           mem_wb_dest;
  logic [31:0]          mem_wb_result;
  // MEM -> ID forwarding
  logic                 mem_fwd_valid;
  logic                 mem_fwd_pending;
  logic [4:0]           mem_fwd_dest;
  logic [31:0]          mem_fwd_data;
  // status
  logic                 mem_discard_busy;

  modport slave (
    input  ex_mem_valid, ex_mem_payload, ex_mem_req, ex_mem_ld, ex_mem_type,
           ex_mem_addr_low2, ex_mem_gr_we, ex_mem_dest, ex_mem_alu_result,
           data_sram_data_ok, data_sram_rdata, mem_flush, wb_allowin,
    output mem_allowin, mem_wb_valid, mem_wb_payload, mem_wb_gr_we,
           mem_wb_dest, mem_wb_result, mem_fwd_valid, mem_fwd_pending,
           mem_fwd_dest, mem_fwd_data, mem_discard_busy
  );

  modport master (
    output ex_mem_valid, ex_mem_payload, ex_mem_req, ex_mem_ld, ex_mem_type,
           ex_mem_addr_low2, ex_mem_gr_we, ex_mem_dest, ex_mem_alu_result,
           data_sram_data_ok, data_sram_rdata, mem_flush, wb_allowin,
    input  mem_allowin, mem_wb_valid, mem_wb_payload, mem_wb_gr_we,
           mem_wb_dest, mem_wb_result, mem_fwd_valid, mem_fwd_pending,
           mem_fwd_dest, mem_fwd_data, mem_discard_busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_vl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_vl
//  Brief    : Pipeline MEM stage for a variable-latency data SRAM (data_ok
//             style). Holds a memory instruction until its in-order response
//             arrives, buffers an early response while WB stalls, extracts
//             and extends load data, forwards results to ID, and counts
//             responses owed to flushed requests so they can be dropped.
//  Options  : define MEM_FWD_EN to enable the ID forwarding outputs;
//             otherwise they are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_vl #(
  parameter int PAYLOAD_W       = 150,
  parameter int MAX_OUTSTANDING = 2
) (
  input wire            clk,
  input wire            reset,
  mem_stage_vl_if.slave bus
);

  localparam int c_CNT_W = (MAX_OUTSTANDING < 1) ? 1 : $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_W+1:0] c_CNT_MAX = MAX_OUTSTANDING[c_CNT_W+1:0];

  // stage control state
  logic                 mem_valid_q, mem_valid_d;
  logic                 got_data_q,  got_data_d;
  logic [31:0]          rdata_buf_q;
  logic [c_CNT_W-1:0]   discard_cnt_q, discard_cnt_d;

  // instruction fields captured on entry
  logic                 mem_req_q;
  logic                 mem_ld_q;
  logic [2:0]           mem_type_q;
  logic [1:0]           addr_low2_q;
  logic                 gr_we_q;
  logic [4:0]           dest_q;
  logic [31:0]          alu_result_q;
  logic [PAYLOAD_W-1:0] payload_q;

  // handshake and response ownership
  logic w_disc_nz;
  logic w_rsp_mine;
  logic w_waiting;
  logic w_ready_go;
  logic w_allowin;
  logic w_enter;

  // A response first pays off a cancelled request; only then is it ours.
  assign w_disc_nz  = (discard_cnt_q != '0);
  assign w_rsp_mine = bus.data_sram_data_ok & ~w_disc_nz;
  assign w_waiting  = mem_valid_q & mem_req_q & ~got_data_q;
  assign w_ready_go = ~mem_req_q | got_data_q | w_rsp_mine;
  assign w_allowin  = ~mem_valid_q | (w_ready_go & bus.wb_allowin);
  assign w_enter    = bus.ex_mem_valid & w_allowin & ~bus.mem_flush;

  assign bus.mem_allowin      = w_allowin;
  assign bus.mem_wb_valid     = mem_valid_q & w_ready_go & ~bus.mem_flush;
  assign bus.mem_discard_busy = w_disc_nz;

  // Next valid/got_data: any slot turnover (advance or flush) clears
  // got_data, so a response consumed while leaving is never latched.
  always_comb begin
    mem_valid_d = mem_valid_q;
    got_data_d  = got_data_q;
    if (w_allowin | bus.mem_flush) begin
      mem_valid_d = bus.ex_mem_valid & ~bus.mem_flush;
      got_data_d  = 1'b0;
    end else if (w_waiting & w_rsp_mine) begin
      got_data_d  = 1'b1;
    end
  end

  // Discard counter: add requests cancelled by a flush, subtract one per
  // response absorbed, and saturate at the configured maximum.
  logic                 w_inc_mem;
  logic                 w_inc_ex;
  logic                 w_dec;
  logic [c_CNT_W+1:0]   w_cnt_sum;
  always_comb begin
    w_inc_mem = bus.mem_flush & w_waiting & ~w_rsp_mine;
    w_inc_ex  = bus.mem_flush & bus.ex_mem_valid & bus.ex_mem_req;
    w_dec     = bus.data_sram_data_ok & w_disc_nz;
    w_cnt_sum = {2'b00, discard_cnt_q}
              + {{(c_CNT_W+1){1'b0}}, w_inc_mem}
              + {{(c_CNT_W+1){1'b0}}, w_inc_ex}
              - {{(c_CNT_W+1){1'b0}}, w_dec};
    if (w_cnt_sum > c_CNT_MAX) begin
      discard_cnt_d = c_CNT_MAX[c_CNT_W-1:0];
    end else begin
      discard_cnt_d = w_cnt_sum[c_CNT_W-1:0];
    end
  end

  // Control state registers, including the early-response buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q   <= 1'b0;
      got_data_q    <= 1'b0;
      rdata_buf_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      got_data_q    <= got_data_d;
      discard_cnt_q <= discard_cnt_d;
      if (w_waiting & w_rsp_mine) begin
        rdata_buf_q <= bus.data_sram_rdata;
      end
    end
  end

  // Capture the instruction fields when a new instruction enters from EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q    <= 1'b0;
      mem_ld_q     <= 1'b0;
      mem_type_q   <= '0;
      addr_low2_q  <= '0;
      gr_we_q      <= 1'b0;
      dest_q       <= '0;
      alu_result_q <= '0;
      payload_q    <= '0;
    end else if (w_enter) begin
      mem_req_q    <= bus.ex_mem_req;
      mem_ld_q     <= bus.ex_mem_ld;
      mem_type_q   <= bus.ex_mem_type;
      addr_low2_q  <= bus.ex_mem_addr_low2;
      gr_we_q      <= bus.ex_mem_gr_we;
      dest_q       <= bus.ex_mem_dest;
      alu_result_q <= bus.ex_mem_alu_result;
      payload_q    <= bus.ex_mem_payload;
    end
  end

  // Load data: pick buffered or live word, select lane, then extend.
  logic [31:0] w_src;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ext;
  logic [31:0] w_final;
  always_comb begin
    w_src  = got_data_q ? rdata_buf_q : bus.data_sram_rdata;
    w_half = addr_low2_q[1] ? w_src[31:16] : w_src[15:0];
    case (addr_low2_q)
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
    case (mem_type_q[1:0])
      2'b01:   w_ext = mem_type_q[2] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_ext = mem_type_q[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default: w_ext = w_src;
    endcase
    w_final = mem_ld_q ? w_ext : alu_result_q;
  end

  assign bus.mem_wb_payload = payload_q;
  assign bus.mem_wb_gr_we   = gr_we_q & mem_valid_q;
  assign bus.mem_wb_dest    = dest_q;
  assign bus.mem_wb_result  = w_final;

`ifdef MEM_FWD_EN
  // A load still waiting for its data makes ID stall instead of forwarding.
  assign bus.mem_fwd_valid   = mem_valid_q & gr_we_q;
  assign bus.mem_fwd_pending = mem_valid_q & gr_we_q & mem_ld_q & ~w_ready_go;
  assign bus.mem_fwd_dest    = dest_q;
  assign bus.mem_fwd_data    = w_final;
`else
  assign bus.mem_fwd_valid   = 1'b0;
  assign bus.mem_fwd_pending = 1'b0;
  assign bus.mem_fwd_dest    = '0;
  assign bus.mem_fwd_data    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_vl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_vl
//  Brief    : Self-checking bench for mem_stage_vl. Test tasks drive EX, SRAM
//             and WB, and push the expected WB results into a scoreboard. A
//             monitor pops the scoreboard on each WB handoff.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_vl;
  localparam int PW = 150;
`ifdef MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_stage_vl_if #(.PAYLOAD_W(PW)) bus ();

  mem_stage_vl #(.PAYLOAD_W(PW), .MAX_OUTSTANDING(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   res;
    logic [4:0]    dest;
    logic [PW-1:0] pay;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic idle();
    bus.ex_mem_valid = 0; bus.ex_mem_req = 0; bus.ex_mem_ld = 0;
    bus.ex_mem_type = '0; bus.ex_mem_addr_low2 = '0; bus.ex_mem_gr_we = 0;
    bus.ex_mem_dest = '0; bus.ex_mem_alu_result = '0; bus.ex_mem_payload = '0;
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = '0;
    bus.mem_flush = 0; bus.wb_allowin = 1;
  endtask

  task automatic drive_ex(input bit req, input bit ld, input logic [2:0] typ,
                          input logic [1:0] low2, input logic [4:0] dest,
                          input logic [31:0] alu);
    bus.ex_mem_valid = 1; bus.ex_mem_req = req; bus.ex_mem_ld = ld;
    bus.ex_mem_type = typ; bus.ex_mem_addr_low2 = low2; bus.ex_mem_gr_we = 1;
    bus.ex_mem_dest = dest; bus.ex_mem_alu_result = alu;
    bus.ex_mem_payload = rand_payload();
  endtask

  task automatic push_exp(input logic [31:0] res);
    exp_t e;
    e.res = res; e.dest = bus.ex_mem_dest; e.pay = bus.ex_mem_payload;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every WB handoff must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b0 && bus.mem_wb_valid === 1'b1 && bus.wb_allowin === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got result %h with empty scoreboard", bus.mem_wb_result);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (bus.mem_wb_result !== mon_e.res) begin
          errors++; $display("FAIL wb_result: got %h expected %h", bus.mem_wb_result, mon_e.res);
        end
        checks++;
        if (bus.mem_wb_dest !== mon_e.dest) begin
          errors++; $display("FAIL wb_dest: got %0d expected %0d", bus.mem_wb_dest, mon_e.dest);
        end
        checks++;
        if (bus.mem_wb_payload !== mon_e.pay) begin
          errors++; $display("FAIL wb_payload: got %h expected %h", bus.mem_wb_payload, mon_e.pay);
        end
        checks++;
        if (bus.mem_wb_gr_we !== 1'b1) begin
          errors++; $display("FAIL wb_gr_we: got %b expected 1", bus.mem_wb_gr_we);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1; idle();
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b expected 0", bus.mem_wb_valid); end
    checks++; if (bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %b expected 1", bus.mem_allowin); end
    checks++; if (bus.mem_fwd_valid !== 1'b0 || bus.mem_fwd_pending !== 1'b0) begin errors++; $display("FAIL rst_fwd: got %b%b expected 00", bus.mem_fwd_valid, bus.mem_fwd_pending); end
    checks++; if (bus.mem_discard_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.mem_discard_busy); end
    checks++; if (bus.mem_wb_result !== 32'h0 || bus.mem_wb_gr_we !== 1'b0 || bus.mem_wb_dest !== 5'd0) begin errors++; $display("FAIL rst_data: got %h/%b/%0d expected 0/0/0", bus.mem_wb_result, bus.mem_wb_gr_we, bus.mem_wb_dest); end
    checks++; if (bus.mem_wb_payload !== '0) begin errors++; $display("FAIL rst_payload: got %h expected 0", bus.mem_wb_payload); end
    reset = 0;
  endtask

  task automatic test_ld_word();
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd5, 32'h0000_1000); push_exp(32'h8000_00F0); #1;
    checks++; if (bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL ldw_allowin: got %b expected 1", bus.mem_allowin); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); #1;
      checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL ldw_wait_valid[%0d]: got %b expected 0", i, bus.mem_wb_valid); end
      checks++; if (bus.mem_fwd_pending !== FWD) begin errors++; $display("FAIL ldw_pending[%0d]: got %b expected %b", i, bus.mem_fwd_pending, FWD); end
      checks++; if (bus.mem_allowin !== 1'b0) begin errors++; $display("FAIL ldw_wait_allowin[%0d]: got %b expected 0", i, bus.mem_allowin); end
    end
    @(negedge clk); idle(); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h8000_00F0; #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL ldw_ok_valid: got %b expected 1", bus.mem_wb_valid); end
    checks++; if (bus.mem_fwd_pending !== 1'b0) begin errors++; $display("FAIL ldw_ok_pending: got %b expected 0", bus.mem_fwd_pending); end
    checks++; if (bus.mem_fwd_data !== (FWD ? 32'h8000_00F0 : 32'h0)) begin errors++; $display("FAIL ldw_fwd_data: got %h expected %h", bus.mem_fwd_data, (FWD ? 32'h8000_00F0 : 32'h0)); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL ldw_after: got %b expected 0", bus.mem_wb_valid); end
  endtask

  task automatic test_ld_ext();
    logic [2:0]  typ [5];
    logic [1:0]  low [5];
    logic [31:0] res [5];
    typ[0] = 3'b010; low[0] = 2'd3; res[0] = 32'hFFFF_FF80;  // ld.b
    typ[1] = 3'b110; low[1] = 2'd3; res[1] = 32'h0000_0080;  // ld.bu
    typ[2] = 3'b001; low[2] = 2'd2; res[2] = 32'hFFFF_80FF;  // ld.h
    typ[3] = 3'b101; low[3] = 2'd0; res[3] = 32'h0000_1234;  // ld.hu
    typ[4] = 3'b010; low[4] = 2'd1; res[4] = 32'h0000_0012;  // ld.b positive
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle(); drive_ex(1, 1, typ[i], low[i], 5'(8 + i), 32'h0000_2000); push_exp(res[i]);
      @(negedge clk); idle(); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h80FF_1234; #1;
      checks++; if (bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL ext_valid[%0d]: got %b expected 1", i, bus.mem_wb_valid); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_ld_buffered();
    @(negedge clk); idle(); drive_ex(1, 1, 3'b101, 2'd2, 5'd9, 32'h0000_3002); push_exp(32'h0000_1234);
    @(negedge clk); idle(); bus.wb_allowin = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h1234_ABCD; #1;
    checks++; if (bus.mem_wb_valid !== 1'b1 || bus.mem_allowin !== 1'b0) begin errors++; $display("FAIL buf_first: got valid %b allowin %b expected 1 0", bus.mem_wb_valid, bus.mem_allowin); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); bus.wb_allowin = 0; bus.data_sram_rdata = 32'hDEAD_BEEF; #1;
      checks++; if (bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL buf_hold_valid[%0d]: got %b expected 1", i, bus.mem_wb_valid); end
      checks++; if (bus.mem_fwd_pending !== 1'b0) begin errors++; $display("FAIL buf_pending[%0d]: got %b expected 0", i, bus.mem_fwd_pending); end
      checks++; if (bus.mem_fwd_data !== (FWD ? 32'h0000_1234 : 32'h0)) begin errors++; $display("FAIL buf_fwd_data[%0d]: got %h expected %h", i, bus.mem_fwd_data, (FWD ? 32'h0000_1234 : 32'h0)); end
    end
    @(negedge clk); idle(); bus.data_sram_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL buf_release: got %b expected 1", bus.mem_allowin); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL buf_after: got %b expected 0", bus.mem_wb_valid); end
  endtask

  task automatic test_flush_discard();
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd3, 32'h0000_4000);
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd4, 32'h0000_4004); bus.mem_flush = 1; #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL fd_flush_valid: got %b expected 0", bus.mem_wb_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.discard_cnt_q !== 2'd2) begin errors++; $display("FAIL fd_cnt2: got %0d expected 2", dut.discard_cnt_q); end
    checks++; if (bus.mem_discard_busy !== 1'b1 || bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL fd_busy: got busy %b allowin %b expected 1 1", bus.mem_discard_busy, bus.mem_allowin); end
    @(negedge clk); idle(); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hBAD0_0001; #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL fd_drop1: got %b expected 0", bus.mem_wb_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.discard_cnt_q !== 2'd1) begin errors++; $display("FAIL fd_cnt1: got %0d expected 1", dut.discard_cnt_q); end
    @(negedge clk); idle(); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hBAD0_0002;
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd6, 32'h0000_4008); push_exp(32'h0000_0077); #1;
    checks++; if (bus.mem_discard_busy !== 1'b0) begin errors++; $display("FAIL fd_drained: got %b expected 0", bus.mem_discard_busy); end
    @(negedge clk); idle(); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h0000_0077; #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL fd_third_rsp: got %b expected 1", bus.mem_wb_valid); end
    @(negedge clk); idle();
  endtask

  task automatic test_flush_same_cycle();
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd11, 32'h0000_5000);
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd12, 32'h0000_5004);
    bus.mem_flush = 1; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h0BAD_0BAD; #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL fs_valid: got %b expected 0", bus.mem_wb_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.discard_cnt_q !== 2'd1) begin errors++; $display("FAIL fs_cnt: got %0d expected 1", dut.discard_cnt_q); end
    @(negedge clk); idle(); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h0BAD_0002;
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_discard_busy !== 1'b0) begin errors++; $display("FAIL fs_drained: got %b expected 0", bus.mem_discard_busy); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd13, 32'h0000_6000);
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd14, 32'h0000_6004); bus.mem_flush = 1;
    @(negedge clk); idle(); reset = 1; #1;
    checks++; if (bus.mem_discard_busy !== 1'b1) begin errors++; $display("FAIL rmw_busy_before: got %b expected 1", bus.mem_discard_busy); end
    @(negedge clk); idle(); reset = 0; #1;
    checks++; if (bus.mem_discard_busy !== 1'b0 || bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL rmw_cleared: got busy %b allowin %b expected 0 1", bus.mem_discard_busy, bus.mem_allowin); end
  endtask

  task automatic test_alu();
    @(negedge clk); idle(); drive_ex(0, 0, 3'b000, 2'd1, 5'd7, 32'h0000_0055); push_exp(32'h0000_0055);
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", bus.mem_wb_valid); end
    checks++; if (bus.mem_fwd_valid !== FWD || bus.mem_fwd_pending !== 1'b0) begin errors++; $display("FAIL alu_fwd: got %b%b expected %b0", bus.mem_fwd_valid, bus.mem_fwd_pending, FWD); end
    checks++; if (bus.mem_fwd_data !== (FWD ? 32'h55 : 32'h0) || bus.mem_fwd_dest !== (FWD ? 5'd7 : 5'd0)) begin errors++; $display("FAIL alu_fwd_data: got %h/%0d", bus.mem_fwd_data, bus.mem_fwd_dest); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_wb_valid !== 1'b0 || bus.mem_fwd_valid !== 1'b0) begin errors++; $display("FAIL alu_after: got %b%b expected 00", bus.mem_wb_valid, bus.mem_fwd_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); drive_ex(0, 0, 3'b000, 2'd0, 5'(16 + i), 32'h100 + 32'(i)); push_exp(32'h100 + 32'(i)); #1;
      checks++; if (bus.mem_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin[%0d]: got %b expected 1", i, bus.mem_allowin); end
    end
    @(negedge clk); idle(); drive_ex(1, 1, 3'b000, 2'd0, 5'd20, 32'h0000_7000); push_exp(32'hCAFE_F00D);
    @(negedge clk); idle(); drive_ex(0, 0, 3'b000, 2'd0, 5'd21, 32'h0000_2222); push_exp(32'h0000_2222); #1;
    checks++; if (bus.mem_allowin !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", bus.mem_allowin); end
    @(negedge clk); bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hCAFE_F00D; #1;
    checks++; if (bus.mem_allowin !== 1'b1 || bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_leave: got allowin %b valid %b expected 1 1", bus.mem_allowin, bus.mem_wb_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_next: got %b expected 1", bus.mem_wb_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (bus.mem_wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", bus.mem_wb_valid); end
  endtask

  initial begin
    test_reset();
    test_ld_word();
    test_ld_ext();
    test_ld_buffered();
    test_flush_discard();
    test_flush_same_cycle();
    test_reset_mid_wait();
    test_alu();
    test_back_to_back();
    @(negedge clk); #3;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drained: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
